// File: rtl/pipe_perf_monitor_if.sv
// pipe_perf_monitor_if
// Control, event and readout signals of the pipeline performance monitor.
// The core side (Hazard_Detection/Control plus whoever reads the counters)
// uses the master modport; the monitor itself uses the slave modport.
// Signal names keep their _i/_o suffixes as seen from the monitor.
interface pipe_perf_monitor_if #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32
);
    localparam int SEL_W = $clog2(NUM_EVT + 1);

    logic               start_i;
    logic               clr_i;
    logic [NUM_EVT-1:0] evt_i;
    logic               snap_i;
    logic [SEL_W-1:0]   rd_sel_i;
    logic               rd_shadow_i;
    logic [CNT_W-1:0]   rd_data_o;
    logic               rd_valid_o;
    logic               running_o;
    logic               done_o;
    logic [NUM_EVT:0]   ovf_o;

    modport master (
        output start_i, clr_i, evt_i, snap_i, rd_sel_i, rd_shadow_i,
        input  rd_data_o, rd_valid_o, running_o, done_o, ovf_o
    );

    modport slave (
        input  start_i, clr_i, evt_i, snap_i, rd_sel_i, rd_shadow_i,
        output rd_data_o, rd_valid_o, running_o, done_o, ovf_o
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor
// Pipeline performance monitor: NUM_EVT saturating event counters plus one
// saturating cycle counter, counted only while a measurement window runs.
// The window opens on start_i and closes after MAX_CYCLES counting edges
// (MAX_CYCLES = 0 keeps it open until clr_i). Counters are read through a
// registered select port; select value NUM_EVT addresses the cycle counter.
//
// Optional feature macro: PERF_SNAPSHOT_EN
//   defined   -> a shadow bank is built, snap_i copies the live counters into
//                it and rd_shadow_i selects it for readout.
//   undefined -> no shadow storage; snap_i and rd_shadow_i are ignored.
module pipe_perf_monitor #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pipe_perf_monitor_if.slave  bus
);

    localparam int               NUM_CNT     = NUM_EVT + 1;
    localparam int               SEL_W       = $clog2(NUM_EVT + 1);
    localparam logic [SEL_W-1:0] CYC_SEL     = SEL_W'(NUM_EVT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] WIN_LEN     = CNT_W'(MAX_CYCLES);
    localparam bit               WIN_BOUNDED = (MAX_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [NUM_EVT:0] ovf_q, ovf_d;
    logic [NUM_EVT:0] inc_req;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    // The cycle counter sits at index NUM_EVT and is requested every edge.
    assign inc_req = {1'b1, bus.evt_i};

    // Next-state for counters, overflow flags and window FSM; clear wins last.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
        end

        if (state_q == ST_RUN) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (inc_req[k]) begin
                    if (cnt_q[k] == CNT_MAX) begin
                        ovf_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + 1'b1;
                    end
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (WIN_BOUNDED && (cnt_d[NUM_EVT] == WIN_LEN)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.clr_i) begin
            state_d = ST_IDLE;
            ovf_d   = '0;
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_d[k] = '0;
            end
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // Window state, live counters, flags and status outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            ovf_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
            done_q    <= done_d;
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shd_q [NUM_CNT];
    logic [CNT_W-1:0] shd_d [NUM_CNT];

    // Shadow bank copies the pre-edge live values, so a snapshot taken on a
    // counting or clearing edge holds what was visible before that edge.
    always_comb begin
        for (int k = 0; k < NUM_CNT; k++) begin
            shd_d[k] = shd_q[k];
            if (bus.snap_i) begin
                shd_d[k] = cnt_q[k];
            end
        end
    end

    // Shadow storage survives clr_i and is only emptied by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                shd_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                shd_q[k] <= shd_d[k];
            end
        end
    end

    // Read mux over live or shadow bank; out-of-range selects return zero.
    always_comb begin
        rd_valid_d = (bus.rd_sel_i <= CYC_SEL);
        rd_data_d  = '0;
        if (rd_valid_d) begin
            if (bus.rd_shadow_i) begin
                rd_data_d = shd_q[bus.rd_sel_i];
            end else begin
                rd_data_d = cnt_q[bus.rd_sel_i];
            end
        end
    end
`else
    logic unused_snapshot;
    assign unused_snapshot = bus.snap_i | bus.rd_shadow_i;

    // Read mux over the live bank only; out-of-range selects return zero.
    always_comb begin
        rd_valid_d = (bus.rd_sel_i <= CYC_SEL);
        rd_data_d  = '0;
        if (rd_valid_d) begin
            rd_data_d = cnt_q[bus.rd_sel_i];
        end
    end
`endif

    // Registered read port, one cycle behind the select.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.running_o  = running_q;
    assign bus.done_o     = done_q;
    assign bus.ovf_o      = ovf_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor
// Directed bench for pipe_perf_monitor. Two instances share clock and reset:
// u_win (CNT_W=32, MAX_CYCLES=64) for window, readout, clear and snapshot
// behaviour, and u_sat (CNT_W=8, MAX_CYCLES=0) for saturation and overflow.
// Inputs change and outputs are sampled on the falling clock edge.
// Snapshot expectations follow the PERF_SNAPSHOT_EN macro.
module tb_pipe_perf_monitor;

`ifdef PERF_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_perf_monitor_if #(.NUM_EVT(4), .CNT_W(32)) if_a ();
    pipe_perf_monitor_if #(.NUM_EVT(4), .CNT_W(8))  if_b ();

    pipe_perf_monitor #(
        .NUM_EVT    (4),
        .CNT_W      (32),
        .MAX_CYCLES (64)
    ) u_win (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if_a)
    );

    pipe_perf_monitor #(
        .NUM_EVT    (4),
        .CNT_W      (8),
        .MAX_CYCLES (0)
    ) u_sat (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (if_b)
    );

    // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic start, input logic clr,
                                 input logic [3:0] evt, input logic snap,
                                 input logic [2:0] sel, input logic shadow);
        if_a.start_i     = start;
        if_a.clr_i       = clr;
        if_a.evt_i       = evt;
        if_a.snap_i      = snap;
        if_a.rd_sel_i    = sel;
        if_a.rd_shadow_i = shadow;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, window, readout, clear, snapshot, async reset, saturation.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        if_b.start_i     = 1'b0;
        if_b.clr_i       = 1'b0;
        if_b.evt_i       = 4'b0000;
        if_b.snap_i      = 1'b0;
        if_b.rd_sel_i    = 3'd0;
        if_b.rd_shadow_i = 1'b0;

        tick(2);
        checkOutput("rst_rd_data", 64'(if_a.rd_data_o), 64'd0);
        checkOutput("rst_rd_valid", 64'(if_a.rd_valid_o), 64'd0);
        checkOutput("rst_running", 64'(if_a.running_o), 64'd0);
        checkOutput("rst_done", 64'(if_a.done_o), 64'd0);
        checkOutput("rst_ovf", 64'(if_a.ovf_o), 64'd0);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Idle read of cycle counter
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);
        tick(1);
        checkOutput("idle_cyc_read", 64'(if_a.rd_data_o), 64'd0);
        checkOutput("idle_rd_valid", 64'(if_a.rd_valid_o), 64'd1);
        checkOutput("idle_running", 64'(if_a.running_o), 64'd0);

        // Start the 64-cycle window; events: ch0 x5, ch1 x2
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);
        tick(1);
        checkOutput("start_running", 64'(if_a.running_o), 64'd1);
        applyStimulus(1'b0, 1'b0, 4'b0011, 1'b0, 3'd4, 1'b0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0, 3'd4, 1'b0);
        tick(3);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);
        tick(58);
        checkOutput("edge63_running", 64'(if_a.running_o), 64'd1);
        checkOutput("edge63_done", 64'(if_a.done_o), 64'd0);
        tick(1);
        checkOutput("edge64_done", 64'(if_a.done_o), 64'd1);
        checkOutput("edge64_running", 64'(if_a.running_o), 64'd0);
        tick(1);
        checkOutput("window_cycles", 64'(if_a.rd_data_o), 64'd64);

        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOutput("evt0_count", 64'(if_a.rd_data_o), 64'd5);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0);
        tick(1);
        checkOutput("evt1_count", 64'(if_a.rd_data_o), 64'd2);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, 1'b0);
        tick(1);
        checkOutput("evt2_count", 64'(if_a.rd_data_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd3, 1'b0);
        tick(1);
        checkOutput("evt3_count", 64'(if_a.rd_data_o), 64'd0);
        checkOutput("window_ovf", 64'(if_a.ovf_o), 64'd0);

        // DONE ignores events and start
        applyStimulus(1'b1, 1'b0, 4'b1111, 1'b0, 3'd0, 1'b0);
        tick(2);
        checkOutput("done_holds", 64'(if_a.done_o), 64'd1);
        checkOutput("done_no_count", 64'(if_a.rd_data_o), 64'd5);

        // clr_i with start_i in DONE -> IDLE, counters cleared
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 3'd4, 1'b0);
        tick(1);
        checkOutput("clr_running", 64'(if_a.running_o), 64'd0);
        checkOutput("clr_done", 64'(if_a.done_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd4, 1'b0);
        tick(1);
        checkOutput("clr_cyc_zero", 64'(if_a.rd_data_o), 64'd0);
        checkOutput("clr_stays_idle", 64'(if_a.running_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd5, 1'b0);
        tick(1);
        checkOutput("oor5_data", 64'(if_a.rd_data_o), 64'd0);
        checkOutput("oor5_valid", 64'(if_a.rd_valid_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd7, 1'b0);
        tick(1);
        checkOutput("oor7_valid", 64'(if_a.rd_valid_o), 64'd0);

        // Snapshot: ch0 reaches 10, snap on an edge that also counts
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b0);
        tick(10);
        applyStimulus(1'b0, 1'b0, 4'b0001, 1'b1, 3'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOutput("snap_live", 64'(if_a.rd_data_o), 64'd11);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
        tick(1);
        checkOutput("snap_shadow", 64'(if_a.rd_data_o), SNAP ? 64'd10 : 64'd11);
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOutput("snap_clr_live", 64'(if_a.rd_data_o), 64'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b1);
        tick(1);
        checkOutput("snap_clr_shadow", 64'(if_a.rd_data_o), SNAP ? 64'd10 : 64'd0);

        // Short asynchronous reset mid-RUN, between clock edges
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b0);
        tick(3);
        checkOutput("prereset_running", 64'(if_a.running_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rd_data", 64'(if_a.rd_data_o), 64'd0);
        checkOutput("async_rd_valid", 64'(if_a.rd_valid_o), 64'd0);
        checkOutput("async_running", 64'(if_a.running_o), 64'd0);
        checkOutput("async_done", 64'(if_a.done_o), 64'd0);
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOutput("postreset_idle", 64'(if_a.running_o), 64'd0);
        checkOutput("postreset_cnt0", 64'(if_a.rd_data_o), 64'd0);
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b0);
        tick(3);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0);
        tick(1);
        checkOutput("restart_cnt0", 64'(if_a.rd_data_o), 64'd3);

        // Saturation on the 8-bit, unbounded instance
        if_b.start_i = 1'b1;
        tick(1);
        if_b.start_i = 1'b0;
        if_b.evt_i   = 4'b0001;
        tick(300);
        if_b.evt_i   = 4'b0000;
        checkOutput("sat_ovf", 64'(if_b.ovf_o), 64'b10001);
        checkOutput("sat_running", 64'(if_b.running_o), 64'd1);
        if_b.rd_sel_i = 3'd0;
        tick(1);
        checkOutput("sat_cnt0", 64'(if_b.rd_data_o), 64'd255);
        if_b.rd_sel_i = 3'd4;
        tick(1);
        checkOutput("sat_cycles", 64'(if_b.rd_data_o), 64'd255);
        if_b.rd_sel_i = 3'd1;
        tick(1);
        checkOutput("sat_cnt1", 64'(if_b.rd_data_o), 64'd0);
        if_b.clr_i = 1'b1;
        tick(1);
        if_b.clr_i = 1'b0;
        checkOutput("sat_clr_ovf", 64'(if_b.ovf_o), 64'd0);
        checkOutput("sat_clr_running", 64'(if_b.running_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Parametrised pipeline performance monitor for the pipelined CPU. It counts per-cycle hazard events (stall, flush, and any others the core exports) plus elapsed cycles over a bounded measurement window. It replaces bench-side stall/flush counting with synthesizable counters that have saturation, overflow flags and snapshot readout. It sits beside the CPU top, taking event strobes from Hazard_Detection/Control, and is read through a registered select port.

## Interface
- NUM_EVT, 4, number of event channels (1..16); channel 0 = stall, 1 = flush by integration convention
- CNT_W, 32, width of every counter (8..64)
- MAX_CYCLES, 64, window length in cycles; 0 = unbounded
- SEL_W, $clog2(NUM_EVT+1), width of read select (derived, not overridden)
- clk_i  in  1  clock, all state changes on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  level; begins a window when in IDLE
- clr_i  in  1  synchronous clear of counters, flags and state
- evt_i  in  NUM_EVT  per-cycle event strobes, one count per high cycle
- snap_i  in  1  pulse; copy live counters into shadow bank
- rd_sel_i  in  SEL_W  0..NUM_EVT-1 = event counter, NUM_EVT = cycle counter
- rd_shadow_i  in  1  1 = read shadow bank, 0 = live
- rd_data_o  out  CNT_W  registered read data
- rd_valid_o  out  1  high when rd_sel_i was in range on the previous edge
- running_o  out  1  state == RUN
- done_o  out  1  state == DONE
- ovf_o  out  NUM_EVT+1  sticky saturation flags; bit NUM_EVT = cycle counter

## Operation
- Reset (rst_i=0, async): state IDLE; all live/shadow counters 0; rd_data_o=0, rd_valid_o=0, running_o=0, done_o=0, ovf_o=0.
- FSM: IDLE -> RUN on start_i=1. RUN -> DONE on the edge where cycle counter reaches MAX_CYCLES (never if MAX_CYCLES=0). DONE holds until clr_i. start_i in RUN/DONE is ignored.
- clr_i=1 in any state: next state IDLE; live counters and ovf_o zeroed; shadow bank untouched. clr_i beats start_i in the same cycle.
- Counting: only on edges where state is RUN, including the edge that moves to DONE. Cycle counter +1 per such edge. Event counter k +1 when evt_i[k]=1.
- Saturation: a counter at all-ones stays at all-ones and sets its ovf_o bit. The bit stays set until clr_i or reset. No wrap-around.
- Readout: rd_data_o <= selected counter each edge. Out-of-range rd_sel_i gives rd_data_o=0 and rd_valid_o=0.

## Timing
- Read latency: 1 cycle from rd_sel_i/rd_shadow_i to rd_data_o/rd_valid_o.
- A live read shows the counter value after the previous edge, so an event in cycle n is visible on rd_data_o at edge n+2.
- running_o/done_o are decoded from registered state, valid the cycle after the transition edge.
- snap_i together with a count edge: shadow captures the pre-increment value.
- snap_i together with clr_i: shadow captures pre-clear values and live counters clear.
- Reset asserted mid-window: immediate return to IDLE. Nothing is retained.

## Configuration
- PERF_SNAPSHOT_EN defined: shadow bank (NUM_EVT+1 x CNT_W) is built; snap_i and rd_shadow_i are honoured.
- PERF_SNAPSHOT_EN undefined: no shadow storage; snap_i and rd_shadow_i are ignored; reads always return live counters.

## Test plan
- Reset, then start_i=1 with evt_i=0 and MAX_CYCLES=64 -> done_o rises after 64 counting edges; cycle read (rd_sel_i=NUM_EVT) = 64; all event counts 0.
- evt_i[0] high for 5 cycles and evt_i[1] high for 2 cycles during RUN -> reads of channel 0 = 5 and channel 1 = 2, one cycle after select.
- CNT_W=8, evt_i[0] held high for 300 RUN cycles (MAX_CYCLES=0) -> channel 0 reads 255; ovf_o[0]=1, ovf_o[NUM_EVT]=1; other flags 0.
- PERF_SNAPSHOT_EN: snap_i when channel 0 = 10 with evt_i[0]=1 on that edge -> shadow read = 10, live = 11; then clr_i -> live 0, shadow still 10.
- clr_i and start_i together in DONE -> state IDLE, counters 0, running_o=0; rd_sel_i=NUM_EVT+1 -> rd_data_o=0, rd_valid_o=0.
- rst_i low mid-RUN for less than one cycle, asynchronously -> all outputs 0 immediately; start_i after release restarts counting from 0.
